alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Control-step sequencer that sits directly upstream of the datapath ALU and drives its one-hot operation selects (NOT, OR, AND, SHR, SHRA, SHL).
- Steps the bus CPU through fetch and execute of register-register logical and shift instructions.
- Issues the register-file, RY, Z, PC, MAR, MDR and IR strobes, one control step per clock.
- Waits on a memory-ready handshake during fetch.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- REGW, 4, register-select field width (Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset; asynchronous, active-low.
- run  in  1  1 = sequencer may leave IDLE / continue; sampled only in IDLE and at T5.
- mem_ready  in  1  memory read data valid; completes the T1 handshake.
- ir  in  32  current instruction register contents.
- pc_out, mar_in, inc_pc, pc_in  out  1  PC/MAR strobes.
- read, mdr_in, mdr_out, ir_in  out  1  memory/IR strobes.
- ry_in, z_in, zlo_out  out  1  ALU operand and result register strobes.
- r_out, r_in  out  1  register-file bus-drive / load.
- rsel  out  REGW  register number driven to the register file.
- alu_not, alu_or, alu_and, alu_shr, alu_shra, alu_shl  out  1  one-hot ALU selects.
- illegal  out  1  sticky flag set on an undecodable opcode.
- done  out  1  one-cycle pulse at end of T5.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT.
- Encoding: one-hot or binary; not visible at the ports.
- Reset (clear=0, asynchronous):
  - state=IDLE.
  - All outputs 0, rsel=0, illegal=0.
  - Reset mid-instruction abandons it immediately; no strobe may remain asserted.
- All strobes are Moore outputs decoded from state and the registered ir. At most one bus driver is active per state.
- IDLE: outputs 0. run=1 -> T0.
- T0: pc_out, mar_in, inc_pc, z_in. -> T1.
- T1: zlo_out, pc_in, read, mdr_in.
  - pc_in is asserted only in the first cycle of T1.
  - read and mdr_in hold until mem_ready=1.
  - Leave T1 on the cycle mem_ready=1 is sampled. mem_ready already high on T1 entry -> one-cycle T1.
- T2: mdr_out, ir_in. -> T3.
- T3: opcode decode (from ir, now valid).
  - Illegal opcode -> HALT with illegal=1.
  - Binary ops (AND, OR): r_out, rsel=Rb, ry_in.
  - Unary ops (NOT, SHR, SHRA, SHL): no strobes (RY unused).
  - -> T4.
- T4: r_out and z_in asserted, plus exactly one ALU select for the opcode.
  - Binary ops: rsel=Rc.
  - Unary ops: rsel=Rb.
  - -> T5.
- T5: zlo_out, r_in, rsel=Ra, done=1.
  - run=1 -> T0; run=0 -> IDLE.
- HALT: all strobes 0; illegal held at 1. Exit only via clear.
- ALU selects are never asserted outside T4 and are mutually exclusive.
- run deasserted mid-instruction has no effect until T5.
- Latency: 6 cycles per instruction with zero memory wait states; T1 adds one cycle per wait state.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - opcode constants OP_AND=5'b00101, OP_OR=5'b00110, OP_SHR=5'b00111, OP_SHRA=5'b01000, OP_SHL=5'b01001, OP_NOT=5'b10010;
  - state enum;
  - IR field bit positions.
- One sub-module: alu_op_decode. Combinational map from opcode to {legal, binary, one-hot select[5:0]}; reused by the future control unit.

Test Plan:
- Reset: clear low during T4 with alu_and=1 -> all outputs 0 asynchronously, before the next clock edge. Release with run=1 -> T0 strobes on the next edge.
- AND, Ra=3, Rb=4, Rc=5, mem_ready tied 1 -> six cycles:
  - T3: rsel=4 with ry_in.
  - T4: rsel=5, alu_and only, z_in.
  - T5: rsel=3, r_in, done=1.
- SHRA, Ra=1, Rb=2 -> no ry_in in T3; T4: rsel=2, alu_shra=1, other selects 0.
- Memory wait: mem_ready low for 3 cycles in T1 -> read/mdr_in held 4 cycles, pc_in only in the first. Instruction completes in 9 cycles.
- Illegal opcode 5'b11111 -> HALT after T3, illegal=1 stays high, no z_in/r_in issued. clear returns to IDLE with illegal=0.
- Back-to-back: run held 1 for OR then NOT -> T0 immediately follows T5, done pulses exactly twice, no IDLE cycle.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control path.
//   - opcode constants for the register-register logical and shift instructions
//   - control-step state enumeration
//   - IR field bit positions and ALU select bit positions
package alu_ctrl_pkg;

    localparam int OPCODE_W = 5;
    localparam int REGSEL_W = 4;

    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b10010;

    // IR field LSB positions: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    // Bit positions inside the one-hot ALU select vector
    localparam int SEL_NOT  = 5;
    localparam int SEL_OR   = 4;
    localparam int SEL_AND  = 3;
    localparam int SEL_SHR  = 2;
    localparam int SEL_SHRA = 1;
    localparam int SEL_SHL  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder.
//   opcode_i : instruction opcode field
//   legal_o  : opcode is one of the supported logical/shift operations
//   binary_o : operation takes two register operands (AND, OR)
//   sel_o    : one-hot ALU select {NOT, OR, AND, SHR, SHRA, SHL}; all zero when illegal
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic                legal_o,
    output logic                binary_o,
    output logic [5:0]          sel_o
);

    always_comb begin
        legal_o  = 1'b1;
        binary_o = 1'b0;
        sel_o    = 6'b0;
        case (opcode_i)
            OP_AND:  begin sel_o[SEL_AND] = 1'b1; binary_o = 1'b1; end
            OP_OR:   begin sel_o[SEL_OR]  = 1'b1; binary_o = 1'b1; end
            OP_NOT:  sel_o[SEL_NOT]  = 1'b1;
            OP_SHR:  sel_o[SEL_SHR]  = 1'b1;
            OP_SHRA: sel_o[SEL_SHRA] = 1'b1;
            OP_SHL:  sel_o[SEL_SHL]  = 1'b1;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control-step sequencer for fetch/execute of register-register logical and
// shift instructions. All strobes are Moore outputs of the step register and
// the IR contents, so an asynchronous clear drops every strobe at once.
//   clock, clear     : rising-edge clock, asynchronous active-low reset
//   run              : permission to start / continue (sampled in IDLE and T5)
//   mem_ready        : memory read data valid, ends the T1 wait
//   ir               : instruction register contents (valid from T3 onward)
//   pc_out..ir_in    : PC, MAR, memory and IR strobes
//   ry_in, z_in, zlo_out, r_out, r_in, rsel : ALU operand/result and regfile controls
//   alu_*            : one-hot ALU selects, T4 only
//   illegal          : sticky, high while halted on an undecodable opcode
//   done             : one-cycle pulse in T5
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int OPW  = OPCODE_W,
    parameter int REGW = REGSEL_W
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic            mem_ready,
    input  logic [31:0]     ir,
    output logic            pc_out,
    output logic            mar_in,
    output logic            inc_pc,
    output logic            pc_in,
    output logic            read,
    output logic            mdr_in,
    output logic            mdr_out,
    output logic            ir_in,
    output logic            ry_in,
    output logic            z_in,
    output logic            zlo_out,
    output logic            r_out,
    output logic            r_in,
    output logic [REGW-1:0] rsel,
    output logic            alu_not,
    output logic            alu_or,
    output logic            alu_and,
    output logic            alu_shr,
    output logic            alu_shra,
    output logic            alu_shl,
    output logic            illegal,
    output logic            done
);

    state_e state_q, state_d;
    // High during the first T1 cycle only; T1 is entered solely from T0.
    logic   t1_first_q;

    logic [OPW-1:0]  opcode;
    logic [REGW-1:0] ra, rb, rc;
    logic            op_legal, op_binary;
    logic [5:0]      op_sel;
    logic            unused_ir;

    assign opcode    = ir[IR_OP_LSB +: OPW];
    assign ra        = ir[IR_RA_LSB +: REGW];
    assign rb        = ir[IR_RB_LSB +: REGW];
    assign rc        = ir[IR_RC_LSB +: REGW];
    assign unused_ir = ^ir[IR_RC_LSB-1:0];

    alu_op_decode u_decode (
        .opcode_i (opcode),
        .legal_o  (op_legal),
        .binary_o (op_binary),
        .sel_o    (op_sel)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= S_IDLE;
            t1_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            t1_first_q <= (state_q == S_T0);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (mem_ready) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = op_legal ? S_T4 : S_HALT;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = run ? S_T0 : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        inc_pc   = 1'b0;
        pc_in    = 1'b0;
        read     = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        ry_in    = 1'b0;
        z_in     = 1'b0;
        zlo_out  = 1'b0;
        r_out    = 1'b0;
        r_in     = 1'b0;
        rsel     = '0;
        alu_not  = 1'b0;
        alu_or   = 1'b0;
        alu_and  = 1'b0;
        alu_shr  = 1'b0;
        alu_shra = 1'b0;
        alu_shl  = 1'b0;
        illegal  = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                // Z still holds PC+1 for the whole wait; PC loads it only once.
                zlo_out = 1'b1;
                pc_in   = t1_first_q;
                read    = 1'b1;
                mdr_in  = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                // Unary ops leave RY untouched; illegal ops issue nothing.
                if (op_legal && op_binary) begin
                    r_out = 1'b1;
                    rsel  = rb;
                    ry_in = 1'b1;
                end
            end
            S_T4: begin
                r_out    = 1'b1;
                z_in     = 1'b1;
                rsel     = op_binary ? rc : rb;
                alu_not  = op_sel[SEL_NOT];
                alu_or   = op_sel[SEL_OR];
                alu_and  = op_sel[SEL_AND];
                alu_shr  = op_sel[SEL_SHR];
                alu_shra = op_sel[SEL_SHRA];
                alu_shl  = op_sel[SEL_SHL];
            end
            S_T5: begin
                zlo_out = 1'b1;
                r_in    = 1'b1;
                rsel    = ra;
                done    = 1'b1;
            end
            S_HALT:  illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] ir = '0;
    logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic ry_in, z_in, zlo_out, r_out, r_in;
    logic [3:0] rsel;
    logic alu_not, alu_or, alu_and, alu_shr, alu_shra, alu_shl, illegal, done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [24:0] w;
        string       name;
    } exp_t;
    exp_t q[$];

    always #5 clock = ~clock;

    alu_op_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .pc_in(pc_in),
        .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
        .ry_in(ry_in), .z_in(z_in), .zlo_out(zlo_out), .r_out(r_out), .r_in(r_in),
        .rsel(rsel), .alu_not(alu_not), .alu_or(alu_or), .alu_and(alu_and),
        .alu_shr(alu_shr), .alu_shra(alu_shra), .alu_shl(alu_shl),
        .illegal(illegal), .done(done)
    );

    // Strobe vector bit order: pc_out mar_in inc_pc pc_in read mdr_in mdr_out ir_in ry_in z_in zlo_out r_out r_in
    localparam logic [12:0] ST_NONE = 13'b0;
    localparam logic [12:0] ST_T0   = 13'b1110000001000;
    localparam logic [12:0] ST_T1F  = 13'b0001110000100;
    localparam logic [12:0] ST_T1W  = 13'b0000110000100;
    localparam logic [12:0] ST_T2   = 13'b0000001100000;
    localparam logic [12:0] ST_T3B  = 13'b0000000010010;
    localparam logic [12:0] ST_T4   = 13'b0000000001010;
    localparam logic [12:0] ST_T5   = 13'b0000000000101;
    // ALU select order: not or and shr shra shl
    localparam logic [5:0] A_NONE = 6'b000000;
    localparam logic [5:0] A_NOT  = 6'b100000;
    localparam logic [5:0] A_OR   = 6'b010000;
    localparam logic [5:0] A_AND  = 6'b001000;
    localparam logic [5:0] A_SHRA = 6'b000010;

    function automatic logic [24:0] mk(input logic [12:0] s, input logic [3:0] r,
                                       input logic [5:0] a, input logic il, input logic dn);
        return {s, r, a, il, dn};
    endfunction

    function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'b0};
    endfunction

    wire [24:0] act = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
                       ry_in, z_in, zlo_out, r_out, r_in, rsel,
                       alu_not, alu_or, alu_and, alu_shr, alu_shra, alu_shl, illegal, done};

    // Monitor: one expected output word per cycle, compared mid-cycle.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (act !== e.w) begin
                n_fail++;
                $display("FAIL %s got=%b exp=%b", e.name, act, e.w);
            end
        end
    end

    // Push the expectation for the current cycle, then advance one clock.
    task automatic cyc(input logic [24:0] w, input string name);
        exp_t e;
        e.w = w;
        e.name = name;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input string p, input int waits);
        cyc(mk(ST_T0, 0, A_NONE, 0, 0), {p, ".T0"});
        cyc(mk(ST_T1F, 0, A_NONE, 0, 0), {p, ".T1"});
        for (int i = 0; i < waits; i++) begin
            if (i == waits - 1) mem_ready = 1'b1;
            cyc(mk(ST_T1W, 0, A_NONE, 0, 0), {p, ".T1w"});
        end
        cyc(mk(ST_T2, 0, A_NONE, 0, 0), {p, ".T2"});
    endtask

    initial begin
        @(posedge clock);
        #1;
        // Reset state
        cyc(25'b0, "reset0");
        cyc(25'b0, "reset1");
        clear = 1'b1;
        cyc(25'b0, "idle_run0");

        // AND R3 = R4 & R5, no wait states; run dropped mid-instruction
        ir = mkir(5'b00101, 4'd3, 4'd4, 4'd5);
        run = 1'b1;
        cyc(25'b0, "and.idle");
        run = 1'b0;
        fetch("and", 0);
        cyc(mk(ST_T3B, 4'd4, A_NONE, 0, 0), "and.T3");
        cyc(mk(ST_T4, 4'd5, A_AND, 0, 0), "and.T4");
        cyc(mk(ST_T5, 4'd3, A_NONE, 0, 1), "and.T5");
        cyc(25'b0, "and.idle_after");

        // SHRA R1 = R2 >>> 1 (unary)
        ir = mkir(5'b01000, 4'd1, 4'd2, 4'd0);
        run = 1'b1;
        cyc(25'b0, "shra.idle");
        run = 1'b0;
        fetch("shra", 0);
        cyc(mk(ST_NONE, 0, A_NONE, 0, 0), "shra.T3");
        cyc(mk(ST_T4, 4'd2, A_SHRA, 0, 0), "shra.T4");
        cyc(mk(ST_T5, 4'd1, A_NONE, 0, 1), "shra.T5");
        cyc(25'b0, "shra.idle_after");

        // OR with three memory wait states: 9-cycle instruction
        ir = mkir(5'b00110, 4'd7, 4'd8, 4'd9);
        run = 1'b1;
        cyc(25'b0, "wait.idle");
        run = 1'b0;
        mem_ready = 1'b0;
        fetch("wait", 3);
        cyc(mk(ST_T3B, 4'd8, A_NONE, 0, 0), "wait.T3");
        cyc(mk(ST_T4, 4'd9, A_OR, 0, 0), "wait.T4");
        cyc(mk(ST_T5, 4'd7, A_NONE, 0, 1), "wait.T5");
        cyc(25'b0, "wait.idle_after");

        // Back-to-back OR then NOT with run held high
        ir = mkir(5'b00110, 4'd2, 4'd3, 4'd4);
        run = 1'b1;
        cyc(25'b0, "b2b.idle");
        fetch("b2b.or", 0);
        cyc(mk(ST_T3B, 4'd3, A_NONE, 0, 0), "b2b.or.T3");
        cyc(mk(ST_T4, 4'd4, A_OR, 0, 0), "b2b.or.T4");
        cyc(mk(ST_T5, 4'd2, A_NONE, 0, 1), "b2b.or.T5");
        ir = mkir(5'b10010, 4'd5, 4'd6, 4'd0);
        fetch("b2b.not", 0);
        run = 1'b0;
        cyc(mk(ST_NONE, 0, A_NONE, 0, 0), "b2b.not.T3");
        cyc(mk(ST_T4, 4'd6, A_NOT, 0, 0), "b2b.not.T4");
        cyc(mk(ST_T5, 4'd5, A_NONE, 0, 1), "b2b.not.T5");
        cyc(25'b0, "b2b.idle_after");

        // Illegal opcode halts after T3; run cannot leave HALT
        ir = mkir(5'b11111, 4'd1, 4'd2, 4'd3);
        run = 1'b1;
        cyc(25'b0, "ill.idle");
        run = 1'b0;
        fetch("ill", 0);
        cyc(mk(ST_NONE, 0, A_NONE, 0, 0), "ill.T3");
        run = 1'b1;
        for (int i = 0; i < 3; i++) cyc(mk(ST_NONE, 0, A_NONE, 1, 0), "ill.halt");
        run = 1'b0;
        clear = 1'b0;
        cyc(25'b0, "ill.clear");
        clear = 1'b1;
        cyc(25'b0, "ill.idle_after");

        // Asynchronous clear during T4 of an AND
        ir = mkir(5'b00101, 4'd3, 4'd4, 4'd5);
        run = 1'b1;
        cyc(25'b0, "rst.idle");
        run = 1'b0;
        fetch("rst", 0);
        cyc(mk(ST_T3B, 4'd4, A_NONE, 0, 0), "rst.T3");
        n_checks++;
        if (alu_and !== 1'b1) begin
            n_fail++;
            $display("FAIL rst.T4_alu_and got=%b exp=1", alu_and);
        end
        begin
            exp_t e;
            e.w = 25'b0;
            e.name = "rst.async_clear";
            q.push_back(e);
        end
        #1 clear = 1'b0;
        @(posedge clock);
        #1;
        run = 1'b1;
        clear = 1'b1;
        cyc(25'b0, "rst.idle_release");
        run = 1'b0;
        fetch("rst2", 0);
        cyc(mk(ST_T3B, 4'd4, A_NONE, 0, 0), "rst2.T3");
        cyc(mk(ST_T4, 4'd5, A_AND, 0, 0), "rst2.T4");
        cyc(mk(ST_T5, 4'd3, A_NONE, 0, 1), "rst2.T5");
        cyc(25'b0, "rst2.idle_after");

        @(posedge clock);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
